// File: rtl/mix_columns_seq.sv
// ============================================================================
// mix_columns_seq : AES MixColumns, one column per clock, valid/ready both ends
// Optional INV_MIXCOL_EN adds an 'inv' port selecting InvMixColumns.
// Rev 1.0
// ============================================================================
`default_nettype none

module mix_columns_seq #(
  parameter int NCOL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*NCOL-1:0]   in_state,
`ifdef INV_MIXCOL_EN
  input  logic                 inv,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*NCOL-1:0]   out_state
);

  localparam int COL_W = $clog2(NCOL);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [COL_W-1:0]    col_cnt_q, col_cnt_d;
  logic [32*NCOL-1:0]  data_q, data_d;
  logic [32*NCOL-1:0]  out_state_q, out_state_d;
  logic [31:0]         col_in, col_out;
`ifdef INV_MIXCOL_EN
  logic                inv_q, inv_d;
`endif

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] fwd_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

`ifdef INV_MIXCOL_EN
  // Packs {0e*a, 0b*a, 0d*a, 09*a} built from chained xtime.
  function automatic logic [31:0] inv_mul(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xt(a); x4 = xt(x2); x8 = xt(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a};
  endfunction

  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [31:0] m0, m1, m2, m3;
    m0 = inv_mul(c[31:24]); m1 = inv_mul(c[23:16]);
    m2 = inv_mul(c[15:8]);  m3 = inv_mul(c[7:0]);
    // Field order in m*: [31:24]=e, [23:16]=b, [15:8]=d, [7:0]=9
    return {m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0],
            m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8],
            m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16],
            m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24]};
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_cnt_q   <= '0;
      data_q      <= '0;
      out_state_q <= '0;
`ifdef INV_MIXCOL_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      data_q      <= data_d;
      out_state_q <= out_state_d;
`ifdef INV_MIXCOL_EN
      inv_q       <= inv_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_BUSY;
      S_BUSY:  if (col_cnt_q == COL_W'(NCOL-1)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    col_in = '0;
    for (int c = 0; c < NCOL; c++) begin
      if (col_cnt_q == COL_W'(c)) col_in = data_q[32*NCOL-1-32*c -: 32];
    end
    col_out = fwd_mix(col_in);
`ifdef INV_MIXCOL_EN
    if (inv_q) col_out = inv_mix(col_in);
`endif
  end

  always_comb begin
    col_cnt_d   = col_cnt_q;
    data_d      = data_q;
    out_state_d = out_state_q;
`ifdef INV_MIXCOL_EN
    inv_d       = inv_q;
`endif
    if (state_q == S_IDLE && in_valid) begin
      data_d    = in_state;
      col_cnt_d = '0;
`ifdef INV_MIXCOL_EN
      inv_d     = inv;
`endif
    end else if (state_q == S_BUSY) begin
      for (int c = 0; c < NCOL; c++) begin
        if (col_cnt_q == COL_W'(c)) out_state_d[32*NCOL-1-32*c -: 32] = col_out;
      end
      col_cnt_d = col_cnt_q + 1'b1;
    end
  end

  assign out_state = out_state_q;

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
// ============================================================================
// tb_mix_columns_seq : directed self-checking bench for mix_columns_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
`ifdef INV_MIXCOL_EN
  logic         inv = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] DEG_IN   = 128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c;
  localparam logic [127:0] DEG_OUT  = 128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8;

  always #5 clk = ~clk;

  mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef INV_MIXCOL_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept s, check exact 4-edge latency and result, then drain.
  task automatic test_vector(input string name, input logic [127:0] s,
                             input logic [127:0] exp);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL %s_ready_before: got %b expected 1", name, in_ready);
    end
    in_valid = 1'b1; in_state = s; out_ready = 1'b0;
    step();
    in_valid = 1'b0; in_state = ~s;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (out_valid !== (k == 4)) begin
        failures++; $display("FAIL %s_latency_e%0d: got out_valid=%b expected %b", name, k, out_valid, (k == 4));
      end
    end
    checks++;
    if (out_state !== exp) begin
      failures++; $display("FAIL %s_result: got %h expected %h", name, out_state, exp);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL %s_drain: got valid=%b ready=%b expected 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== '0) begin
      failures++; $display("FAIL reset_init: got valid=%b ready=%b state=%h expected 0 1 0", out_valid, in_ready, out_state);
    end
    in_valid = 1'b1; in_state = FIPS_IN;
    step();
    in_valid = 1'b0;
    step(); step();
    checks++;
    if (out_state === '0) begin
      failures++; $display("FAIL reset_partial_written: got %h expected nonzero", out_state);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== '0) begin
      failures++; $display("FAIL reset_async: got valid=%b ready=%b state=%h expected 0 1 0", out_valid, in_ready, out_state);
    end
    step(); step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_no_pulse: got %b expected 0", out_valid);
    end
    rst_n = 1'b1;
    step();
    test_vector("reset_recover", FIPS_IN, FIPS_OUT);
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_state = DEG_IN; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    for (int k = 0; k < 10; k++) begin
      in_valid = (k == 5); in_state = FIPS_IN;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== DEG_OUT) begin
        failures++; $display("FAIL bp_hold_%0d: got valid=%b ready=%b state=%h expected 1 0 %h", k, out_valid, in_ready, out_state, DEG_OUT);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_no_capture: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_state = FIPS_IN; out_ready = 1'b1;
    step();
    in_state = DEG_IN;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (out_valid !== 1'b1 || out_state !== FIPS_OUT) begin
      failures++; $display("FAIL b2b_first: got valid=%b state=%h expected 1 %h", out_valid, out_state, FIPS_OUT);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_gap: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_second_accept: got ready=%b expected 0", in_ready);
    end
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (out_valid !== 1'b1 || out_state !== DEG_OUT) begin
      failures++; $display("FAIL b2b_second: got valid=%b state=%h expected 1 %h", out_valid, out_state, DEG_OUT);
    end
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_end: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

`ifdef INV_MIXCOL_EN
  task automatic test_inverse();
    inv = 1'b1;
    test_vector("inv_fips", FIPS_OUT, FIPS_IN);
    inv = 1'b0;
    test_vector("inv_off_fwd", FIPS_IN, FIPS_OUT);
  endtask
`endif

  initial begin
    #12;
    rst_n = 1'b1;
    step();
    test_reset();
    test_vector("fips", FIPS_IN, FIPS_OUT);
    test_vector("degenerate", DEG_IN, DEG_OUT);
    test_backpressure();
    test_back_to_back();
`ifdef INV_MIXCOL_EN
    test_inverse();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
